// File: rtl/button_debounce_multi.sv
// Multi-channel button conditioner: two-flop synchroniser, debounce, press/release
// pulses, press toggle and one-shot long-press pulse per channel.
module button_debounce_multi #(
    parameter int                     NUM_BUTTONS       = 4,
    parameter int                     DEBOUNCE_CYCLES   = 1000,
    parameter int                     LONG_PRESS_CYCLES = 50000000,
    parameter logic [NUM_BUTTONS-1:0] TOGGLE_INIT       = {NUM_BUTTONS{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] toggle,
    output logic [NUM_BUTTONS-1:0] long_press
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        logic              sync1_q;
        logic              sync2_q;
        logic [DEB_W-1:0]  deb_cnt_q;
        logic [DEB_W-1:0]  deb_cnt_d;
        logic              level_q;
        logic              level_d;
        logic [HOLD_W-1:0] hold_cnt_q;
        logic [HOLD_W-1:0] hold_cnt_d;
        logic              long_fired_q;
        logic              long_fired_d;
        logic              press_q;
        logic              press_d;
        logic              release_q;
        logic              release_d;
        logic              toggle_q;
        logic              toggle_d;
        logic              long_q;
        logic              long_d;

        // Debounce: accept the synchronised level only after it differs for DEBOUNCE_CYCLES in a row.
        always_comb begin
            deb_cnt_d = deb_cnt_q;
            level_d   = level_q;
            if (sync2_q == level_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                level_d   = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
        end

        // Edge pulses and toggle are derived from the level transition taken on this edge.
        always_comb begin
            press_d   = level_d & ~level_q;
            release_d = level_q & ~level_d;
            toggle_d  = toggle_q ^ press_d;
        end

        // Hold timer: counts registered high level, saturates, fires long-press once per press.
        always_comb begin
            hold_cnt_d   = hold_cnt_q;
            long_fired_d = long_fired_q;
            long_d       = 1'b0;
            if (!level_q) begin
                hold_cnt_d   = '0;
                long_fired_d = 1'b0;
            end else begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
                if ((hold_cnt_q == HOLD_LAST) && !long_fired_q) begin
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end else begin
                    long_d       = 1'b0;
                end
            end
        end

        // Channel state registers with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                deb_cnt_q    <= '0;
                level_q      <= 1'b0;
                hold_cnt_q   <= '0;
                long_fired_q <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                toggle_q     <= TOGGLE_INIT[g];
                long_q       <= 1'b0;
            end else begin
                sync1_q      <= pressed[g];
                sync2_q      <= sync1_q;
                deb_cnt_q    <= deb_cnt_d;
                level_q      <= level_d;
                hold_cnt_q   <= hold_cnt_d;
                long_fired_q <= long_fired_d;
                press_q      <= press_d;
                release_q    <= release_d;
                toggle_q     <= toggle_d;
                long_q       <= long_d;
            end
        end

        assign level[g]         = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign toggle[g]        = toggle_q;
        assign long_press[g]    = long_q;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: a window-based reference model predicts
// every cycle's outputs, a negedge monitor compares; directed scenarios add timing checks.
module tb_button_debounce_multi;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int LP = 10;
    localparam logic [NB-1:0] TINIT = 4'b0000;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] pressed;
    logic [NB-1:0] level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] toggle;
    logic [NB-1:0] long_press;

    int n_checks;
    int n_fail;

    button_debounce_multi #(
        .NUM_BUTTONS      (NB),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .TOGGLE_INIT      (TINIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pressed      (pressed),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .toggle       (toggle),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] pp;
        logic [NB-1:0] rp;
        logic [NB-1:0] tg;
        logic [NB-1:0] lp;
    } out_t;

    out_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: level flips when the last DB synchronised samples all differ from it.
    bit hist [NB][DB+1];
    bit m_lvl [NB];
    bit m_tg [NB];
    int m_rise [NB];
    int edge_n = 0;
    out_t m_e;

    always @(posedge clk) begin
        m_e = '0;
        edge_n++;
        if (!rst_n) begin
            for (int c = 0; c < NB; c++) begin
                for (int i = 0; i <= DB; i++) hist[c][i] = 1'b0;
                m_lvl[c]  = 1'b0;
                m_tg[c]   = TINIT[c];
                m_rise[c] = -1000;
                m_e.tg[c] = TINIT[c];
            end
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit all_diff;
                bit old;
                all_diff = 1'b1;
                for (int i = 1; i <= DB; i++) if (hist[c][i] == m_lvl[c]) all_diff = 1'b0;
                old = m_lvl[c];
                m_e.lp[c] = old && ((edge_n - m_rise[c]) == LP);
                if (all_diff) begin
                    m_lvl[c] = !old;
                    if (!old) begin
                        m_rise[c] = edge_n;
                        m_tg[c]   = !m_tg[c];
                        m_e.pp[c] = 1'b1;
                    end else begin
                        m_e.rp[c] = 1'b1;
                    end
                end
                for (int i = DB; i >= 1; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = pressed[c];
                m_e.lvl[c] = m_lvl[c];
                m_e.tg[c]  = m_tg[c];
            end
        end
        exp_q.push_back(m_e);
    end

    // Monitor: one expected record per edge, compared half a cycle later.
    out_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("level", 32'(level), 32'(mon_e.lvl));
            chk("press_pulse", 32'(press_pulse), 32'(mon_e.pp));
            chk("release_pulse", 32'(release_pulse), 32'(mon_e.rp));
            chk("toggle", 32'(toggle), 32'(mon_e.tg));
            chk("long_press", 32'(long_press), 32'(mon_e.lp));
            chk("press_release_excl", 32'(press_pulse & release_pulse), 32'd0);
            chk("long_press_excl", 32'(long_press & press_pulse), 32'd0);
        end
    end

    logic [NB-1:0] p;

    task automatic drive(input logic r, input logic [NB-1:0] v);
        @(negedge clk);
        rst_n   = r;
        pressed = v;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pp_t;
    int lp_t;
    int rp_t;
    int lp_n;
    int pp_n;
    logic [NB-1:0] tg_seen;
    int seg [NB];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pressed  = '0;
        p        = '0;

        // Reset for two edges, then a clean press on channel 0.
        wait_neg(2);
        chk("reset_outputs", 32'({level, press_pulse, release_pulse, long_press}), 32'd0);
        rst_n = 1'b1;
        wait_neg(2);
        p[0] = 1'b1;
        drive(1'b1, p);
        wait_neg(5);
        chk("ch0_level_before", 32'(level[0]), 32'd0);
        wait_neg(1);
        chk("ch0_level_after", 32'(level[0]), 32'd1);
        chk("ch0_press_pulse", 32'(press_pulse[0]), 32'd1);
        chk("ch0_toggle", 32'(toggle[0]), 32'd1);
        wait_neg(1);
        chk("ch0_press_pulse_end", 32'(press_pulse[0]), 32'd0);

        // Bounce rejection on channel 1.
        pp_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) p[1] = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            else p[1] = 1'b0;
            drive(1'b1, p);
            if (level[1] || press_pulse[1] || toggle[1]) pp_n++;
        end
        chk("ch1_bounce_quiet", 32'(pp_n), 32'd0);

        // Long press on channel 2: hold 30 cycles.
        pp_t = -1; lp_t = -1; rp_t = -1; lp_n = 0;
        p[2] = 1'b1;
        drive(1'b1, p);
        for (int i = 0; i < 45; i++) begin
            if (i == 30) begin
                p[2]    = 1'b0;
                pressed = p;
            end
            @(negedge clk);
            if (press_pulse[2]) pp_t = i;
            if (release_pulse[2]) rp_t = i;
            if (long_press[2]) begin
                lp_n++;
                lp_t = i;
            end
        end
        chk("ch2_press_time", 32'(pp_t), 32'd5);
        chk("ch2_long_count", 32'(lp_n), 32'd1);
        chk("ch2_long_delay", 32'(lp_t - pp_t), 32'd10);
        chk("ch2_release_time", 32'(rp_t), 32'd35);

        // Short (6-cycle) hold: no long press.
        lp_n = 0; pp_n = 0;
        p[2] = 1'b1;
        drive(1'b1, p);
        for (int i = 0; i < 25; i++) begin
            if (i == 6) begin
                p[2]    = 1'b0;
                pressed = p;
            end
            @(negedge clk);
            if (long_press[2]) lp_n++;
            if (press_pulse[2]) pp_n++;
        end
        chk("ch2_short_press", 32'(pp_n), 32'd1);
        chk("ch2_short_no_long", 32'(lp_n), 32'd0);

        // Three clean presses on channel 3.
        tg_seen = '0;
        pp_n    = 0;
        for (int k = 0; k < 3; k++) begin
            p[3] = 1'b1;
            drive(1'b1, p);
            for (int i = 0; i < 16; i++) begin
                if (i == 8) begin
                    p[3]    = 1'b0;
                    pressed = p;
                end
                @(negedge clk);
                if (press_pulse[3]) begin
                    if (pp_n < NB) tg_seen[pp_n] = toggle[3];
                    pp_n++;
                end
            end
        end
        chk("ch3_press_count", 32'(pp_n), 32'd3);
        chk("ch3_toggle_seq", 32'(tg_seen[2:0]), 32'b101);

        // All channels together, then reset while held.
        p = '0;
        drive(1'b1, p);
        wait_neg(12);
        p = 4'b1111;
        drive(1'b1, p);
        wait_neg(6);
        chk("all_press_pulse", 32'(press_pulse), 32'hf);
        wait_neg(2);
        rst_n = 1'b0;
        wait_neg(1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_toggle", 32'(toggle), 32'(TINIT));
        rst_n = 1'b1;
        wait_neg(5);
        chk("rst_no_early_press", 32'(press_pulse), 32'd0);
        wait_neg(1);
        chk("rst_repress_pulse", 32'(press_pulse), 32'hf);
        chk("rst_repress_toggle", 32'(toggle), 32'hf);

        // Random bouncy stimulus with occasional reset pulses.
        for (int c = 0; c < NB; c++) seg[c] = 0;
        for (int n = 0; n < 2000; n++) begin
            logic r;
            for (int c = 0; c < NB; c++) begin
                if (seg[c] == 0) begin
                    p[c]   = ~p[c];
                    seg[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(1, 18));
                end
                seg[c]--;
            end
            r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            drive(r, p);
        end
        drive(1'b1, '0);
        wait_neg(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
